pipelined_adder_v: RTL and testbench

Parametrised, pipelined WIDTH-bit add/subtract unit built from a chain of ripple-carry slices, with valid/ready handshakes on both sides. The operand word is split into STAGES equal slices. Each pipeline stage adds one slice and hands its carry to the next stage, so throughput is one result per clock regardless of WIDTH. The block sits in the arithmetic datapath wherever a wide adder cannot close timing combinationally. It also provides subtract, carry/borrow chaining and signed overflow, which a bare full adder does not.

---
 rtl/pipelined_adder_v_pkg.sv | 8 +
 rtl/pipelined_adder_v_slice.sv | 45 ++++
 rtl/pipelined_adder_v.sv | 140 ++++++++++++++
 tb/tb_pipelined_adder_v.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_v_pkg.sv
// Shared arithmetic definitions for the pipelined add/subtract unit.
// Mode encodings select between A+B+cin and A-B-borrow.
package pipelined_adder_v_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_v_slice.sv
// Combinational ripple-carry building blocks: a one-bit full adder and a
// CHUNK-bit slice that also exposes the carry into its top bit.
module full_adder_v (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_slice_v #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_top
);

   logic [CHUNK:0] carry_s;

   assign carry_s[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      full_adder_v u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (carry_s[i]),
         .s    (s[i]),
         .cout (carry_s[i+1])
      );
   end

   // c_top is the carry into the slice MSB; with cout it yields signed overflow
   assign cout  = carry_s[CHUNK];
   assign c_top = carry_s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder_v.sv
// Pipelined WIDTH-bit add/subtract unit: one CHUNK-bit ripple slice per stage,
// operands skewed forward and result slices deskewed, valid/ready on both sides.
module pipelined_adder_v
   import pipelined_adder_v_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_carry,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_s,
   output logic             o_carry,
   output logic             o_overflow
);

   localparam int CHUNK = WIDTH / STAGES;

   logic en_s;

   // Single global enable: the whole pipe moves or the whole pipe holds
   assign o_ready = ~i_rst & (~o_valid | i_ready);
   assign en_s    = o_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IN_W = WIDTH - k * CHUNK;

      logic [IN_W-1:0]          a_in_s;
      logic [IN_W-1:0]          b_in_s;
      logic                     cin_s;
      logic                     v_in_s;
      logic [CHUNK-1:0]         sum_s;
      logic                     cout_s;
      logic [(k+1)*CHUNK-1:0]   s_r;
      logic                     c_r;
      logic                     v_r;

      if (k == 0) begin : g_entry
         // Subtract is A + ~B + ~borrow
         assign a_in_s = i_a;
         assign b_in_s = (i_sub == MODE_SUB) ? ~i_b : i_b;
         assign cin_s  = (i_sub == MODE_ADD) ? i_carry : ~i_carry;
         assign v_in_s = i_valid;

         // First result slice
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               s_r <= '0;
            end else if (en_s) begin
               s_r <= sum_s;
            end
         end
      end else begin : g_chain
         assign a_in_s = g_stage[k-1].g_mid.a_r;
         assign b_in_s = g_stage[k-1].g_mid.b_r;
         assign cin_s  = g_stage[k-1].c_r;
         assign v_in_s = g_stage[k-1].v_r;

         // Deskew: new slice on top of the lower slices computed earlier
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               s_r <= '0;
            end else if (en_s) begin
               s_r <= {sum_s, g_stage[k-1].s_r};
            end
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [IN_W-CHUNK-1:0] a_r;
         logic [IN_W-CHUNK-1:0] b_r;
         logic                  c_top_unused_s;

         adder_slice_v #(.CHUNK(CHUNK)) u_slice (
            .a     (a_in_s[CHUNK-1:0]),
            .b     (b_in_s[CHUNK-1:0]),
            .cin   (cin_s),
            .s     (sum_s),
            .cout  (cout_s),
            .c_top (c_top_unused_s)
         );

         // Skew: forward operand bits that later stages still have to add
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               a_r <= '0;
               b_r <= '0;
            end else if (en_s) begin
               a_r <= a_in_s[IN_W-1:CHUNK];
               b_r <= b_in_s[IN_W-1:CHUNK];
            end
         end
      end else begin : g_tail
         logic c_top_s;
         logic ov_r;

         adder_slice_v #(.CHUNK(CHUNK)) u_slice (
            .a     (a_in_s[CHUNK-1:0]),
            .b     (b_in_s[CHUNK-1:0]),
            .cin   (cin_s),
            .s     (sum_s),
            .cout  (cout_s),
            .c_top (c_top_s)
         );

         // Signed overflow from the carries around the word MSB
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               ov_r <= 1'b0;
            end else if (en_s) begin
               ov_r <= c_top_s ^ cout_s;
            end
         end
      end

      // Carry and valid hand-off to the next stage
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            c_r <= 1'b0;
            v_r <= 1'b0;
         end else if (en_s) begin
            c_r <= cout_s;
            v_r <= v_in_s;
         end
      end
   end

   assign o_valid    = g_stage[STAGES-1].v_r;
   assign o_s        = g_stage[STAGES-1].s_r;
   assign o_carry    = g_stage[STAGES-1].c_r;
   assign o_overflow = g_stage[STAGES-1].g_tail.ov_r;

endmodule

// File: tb/tb_pipelined_adder_v.sv
// Randomized and directed bench for pipelined_adder_v with an arithmetic
// reference model and an in-order scoreboard of expected results.
module tb_pipelined_adder_v;
   import pipelined_adder_v_pkg::*;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_carry;
   logic             i_sub;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_s;
   logic             o_carry;
   logic             o_overflow;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             c;
      logic             ov;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks    = 0;
   int   failures  = 0;
   int   accepted  = 0;
   int   delivered = 0;
   bit   rand_ready = 1'b0;

   pipelined_adder_v #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_a        (i_a),
      .i_b        (i_b),
      .i_carry    (i_carry),
      .i_sub      (i_sub),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_s        (o_s),
      .o_carry    (o_carry),
      .o_overflow (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unconditioned operands
   function automatic exp_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input logic sub);
      exp_t   r;
      longint ua, ub, sa, sb, u, sr, modv;
      ua   = longint'(a);
      ub   = longint'(b);
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      modv = longint'(1) << WIDTH;
      if (sub) begin
         u    = ua - ub - longint'(cin);
         sr   = sa - sb - longint'(cin);
         r.c  = (u >= 0);
      end else begin
         u    = ua + ub + longint'(cin);
         sr   = sa + sb + longint'(cin);
         r.c  = (u >= modv);
      end
      r.s  = WIDTH'(u);
      r.ov = (sr > (modv / 2) - 1) || (sr < -(modv / 2));
      return r;
   endfunction

   // Scoreboard: decisions taken on the falling edge, ahead of the rising edge
   always @(negedge i_clk) begin
      if (i_rst) begin
         accepted = accepted - exp_q.size();
         exp_q.delete();
      end else begin
         if (o_valid && i_ready) begin
            check_eq("beat_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check_eq("out_s", 32'(o_s), 32'(mon_e.s));
               check_eq("out_carry", 32'(o_carry), 32'(mon_e.c));
               check_eq("out_overflow", 32'(o_overflow), 32'(mon_e.ov));
               delivered++;
            end
         end
         if (i_valid && o_ready) begin
            exp_q.push_back(ref_model(i_a, i_b, i_carry, i_sub));
            accepted++;
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic sub);
      bit done = 1'b0;
      int n = 0;
      i_a = a; i_b = b; i_carry = c; i_sub = sub; i_valid = 1'b1;
      while (!done && n < 200) begin
         @(negedge i_clk);
         if (o_ready) done = 1'b1;
         tick();
         n++;
      end
      check_eq("send_accept", 32'(done), 32'(1));
      i_valid = 1'b0;
   endtask

   task automatic send_rand();
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
           ($urandom_range(0, 1) != 0) ? MODE_SUB : MODE_ADD);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 400) begin
         tick();
         n++;
      end
      check_eq("drain_queue", 32'(exp_q.size()), 32'(0));
      check_eq("drain_valid", 32'(o_valid), 32'(0));
   endtask

   task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic c, input logic sub, input logic [WIDTH-1:0] es,
                           input logic ec, input logic eov);
      send(a, b, c, sub);
      for (int k = 1; k < STAGES; k++) begin
         tick();
         check_eq({tag, "_latency"}, 32'(o_valid), 32'(k == STAGES - 1));
      end
      check_eq({tag, "_s"}, 32'(o_s), 32'(es));
      check_eq({tag, "_carry"}, 32'(o_carry), 32'(ec));
      check_eq({tag, "_ovf"}, 32'(o_overflow), 32'(eov));
      drain();
   endtask

   initial begin
      logic [WIDTH-1:0] held;
      i_rst = 1'b1; i_valid = 1'b0; i_a = '0; i_b = '0;
      i_carry = 1'b0; i_sub = MODE_ADD; i_ready = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check_eq("rst_valid", 32'(o_valid), 32'(0));
      check_eq("rst_ready", 32'(o_ready), 32'(0));
      check_eq("rst_s", 32'(o_s), 32'(0));
      check_eq("rst_carry", 32'(o_carry), 32'(0));
      check_eq("rst_ovf", 32'(o_overflow), 32'(0));
      #2 i_rst = 1'b0;
      i_ready = 1'b1;
      tick();

      directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 16'h0000, 1'b1, 1'b0);
      directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, MODE_SUB, 16'h7FFF, 1'b1, 1'b1);
      directed("add_prop", 16'h0FFF, 16'h0001, 1'b0, MODE_ADD, 16'h1000, 1'b0, 1'b0);
      directed("sub_borrow", 16'h0000, 16'h0000, 1'b1, MODE_SUB, 16'hFFFF, 1'b0, 1'b0);

      // Eight back-to-back beats, A=j, B=2j: outputs are consecutive and in order
      for (int i = 0; i < 8; i++) begin
         send(WIDTH'(i + 1), WIDTH'(2 * (i + 1)), 1'b0, MODE_ADD);
         check_eq("b2b_valid", 32'(o_valid), 32'(i >= STAGES - 1));
         if (i >= STAGES - 1) check_eq("b2b_s", 32'(o_s), 32'(3 * (i - STAGES + 2)));
      end
      for (int k = 1; k < STAGES; k++) begin
         tick();
         check_eq("b2b_tail_valid", 32'(o_valid), 32'(1));
         check_eq("b2b_tail_s", 32'(o_s), 32'(3 * (8 - STAGES + 1 + k)));
      end
      drain();

      // Fill the pipe with the sink stalled, hold, then release
      i_ready = 1'b0;
      for (int i = 0; i < STAGES; i++) send_rand();
      held = o_s;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("bp_valid", 32'(o_valid), 32'(1));
         check_eq("bp_ready", 32'(o_ready), 32'(0));
         check_eq("bp_stable", 32'(o_s), 32'(held));
      end
      i_ready = 1'b1;
      drain();

      // Random traffic with random sink backpressure and input gaps
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) tick();
         else send_rand();
      end
      rand_ready = 1'b0;
      i_ready = 1'b1;
      drain();

      // Reset with a full pipe: everything in flight is discarded
      i_ready = 1'b0;
      for (int i = 0; i < STAGES; i++) send_rand();
      check_eq("mid_full", 32'(o_valid), 32'(1));
      #2 i_rst = 1'b1;
      #1;
      check_eq("mid_rst_valid", 32'(o_valid), 32'(0));
      check_eq("mid_rst_ready", 32'(o_ready), 32'(0));
      check_eq("mid_rst_s", 32'(o_s), 32'(0));
      @(posedge i_clk);
      #3 i_rst = 1'b0;
      i_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("post_rst_valid", 32'(o_valid), 32'(0));
      end
      directed("post_rst", 16'h1234, 16'h4321, 1'b1, MODE_ADD, 16'h5556, 1'b0, 1'b0);

      check_eq("beat_count", 32'(delivered), 32'(accepted));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
